lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
// - LCD image-processing controller. After reset, loads an 8x8 8-bit image (64 px) from an external
//   sync ROM into an internal buffer, then executes 4-bit commands on a 2x2 window around an
//   operation point. Write dumps the buffer to an external RAM and pulses done.
// - Sits between the command source, the image ROM (IROM) and the result RAM (IRAM).
// PARAMETERS
// - DW  8  pixel width (fixed)
// - AW  6  pixel address width, 64 px, addr = row*8 + col (fixed)
// PORTS
// - clk         in   1   single clock, all state updates on rising edge
// - reset       in   1   asynchronous, active-low reset
// - cmd         in   4   command code, sampled with cmd_valid
// - cmd_valid   in   1   command strobe, accepted only at a rising edge with busy=0
// - IROM_rd     out  1   ROM read enable
// - IROM_A      out  6   ROM address
// - IROM_Q      in   8   ROM data; ROM registers mem[IROM_A] on falling clk edge when IROM_rd=1
// - IRAM_valid  out  1   RAM write enable; RAM writes IRAM_D to IRAM_A on falling clk edge
// - IRAM_D      out  8   RAM write data
// - IRAM_A      out  6   RAM write address
// - busy        out  1   1 = not accepting commands
// - done        out  1   one-cycle pulse after Write completes
// BEHAVIOUR
// - Reset values: busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0;
//   point (x,y)=(4,4); FSM=LOAD. Reset mid-operation aborts everything and restarts LOAD.
// - FSM: LOAD -> IDLE -> EXEC -> IDLE, or IDLE -> WRITE -> DONE -> IDLE.
// - LOAD: IROM_rd=1, IROM_A steps 0..63, one per cycle. IROM_Q sampled at an edge holds data for
//   the address driven in the previous cycle; store into buf[prev addr]. After buf[63] is
//   captured: IROM_rd=0, busy=0, go IDLE.
// - IDLE: on rising edge with cmd_valid=1 and busy=0, latch cmd, set busy=1 in that same edge.
//   busy=1 before the stimulus samples it on the next falling edge, so no second command issues.
// - EXEC (all non-Write cmds): one cycle; update buffer/point, busy=0, back to IDLE.
// - Window for point (x,y), x,y in 1..7: TL=buf[(y-1)*8+x-1], TR=buf[(y-1)*8+x],
//   BL=buf[y*8+x-1], BR=buf[y*8+x].
// - 0 Write: enter WRITE. 1 Up: y-1 if y>1. 2 Down: y+1 if y<7. 3 Left: x-1 if x>1.
//   4 Right: x+1 if x<7. At a boundary the shift is a no-op (no wrap).
// - 5 Max: all 4 px = max. 6 Min: all 4 px = min. 7 Average: all 4 px = (TL+TR+BL+BR)>>2.
//   Sum is 10 bits, truncated (floor).
// - 8 CCW rotate: TL'=TR, TR'=BR, BR'=BL, BL'=TL. 9 CW rotate: TL'=BL, TR'=TL, BR'=TR, BL'=BR.
// - 10 Mirror X: swap TL<->BL, TR<->BR. 11 Mirror Y: swap TL<->TR, BL<->BR.
// - 12..15: no-op, busy for one cycle.
// - WRITE: 64 consecutive cycles with IRAM_valid=1, IRAM_A=0..63, IRAM_D=buf[IRAM_A].
//   Outputs change on rising edges only. Then IRAM_valid=0 and go DONE.
// - DONE: done=1 for exactly one cycle, then done=0, busy=0, IDLE. Point and buffer are
//   kept; later commands, including another Write, are accepted.
// - Outputs are registered; no combinational path from cmd/cmd_valid to any output.
// TESTING
// - Reset, image p[i]=i, then Write -> busy=1 for 64 load cycles; IRAM[i]=i for all i;
//   done pulses once, one cycle after the last write.
// - Max at (4,4) with px27..36 = 27,28,35,36 -> px27,28,35,36 all =36.
//   Min on the same data -> all =27.
// - Average with window 1,2,3,5 -> all px =2 (sum 11, floored).
// - CW then CCW on window TL=a, TR=b, BL=c, BR=d -> image restored.
//   A single CW gives TL=c, TR=a, BR=b, BL=d.
// - Four Up cmds from (4,4) -> y stops at 1; then Max affects px 3,4,11,12.
//   Right x8 -> x=7, window cols 6,7.
// - Back-to-back cmd_valid: each command accepted with busy high one cycle, none dropped.
//   Assert reset during WRITE -> done not pulsed, load restarts at IROM_A=0.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - command, image ROM and result RAM signals of the LCD controller
interface lcd_ctrl_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - 8x8 image buffer with 2x2 window commands, loaded from ROM, dumped to RAM
module lcd_ctrl #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  lcd_ctrl_if.master  bus
);
  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   pix [2**AW];
  logic [3:0]      cmd_q;
  logic [2:0]      px, py;
  logic [2:0]      pxm1, pym1;
  logic [AW-1:0]   a_tl, a_tr, a_bl, a_br, wr_nxt;
  logic [DW-1:0]   v_tl, v_tr, v_bl, v_br, mx_t, mx_b, mn_t, mn_b, v_max, v_min;
  logic [DW+1:0]   sum;
  logic            accept;

  // addr = row*8 + col is just {row, col}
  always_comb begin
    pxm1   = px - 3'd1;
    pym1   = py - 3'd1;
    a_tl   = {pym1, pxm1};
    a_tr   = {pym1, px};
    a_bl   = {py, pxm1};
    a_br   = {py, px};
    v_tl   = pix[a_tl];
    v_tr   = pix[a_tr];
    v_bl   = pix[a_bl];
    v_br   = pix[a_br];
    mx_t   = (v_tl > v_tr) ? v_tl : v_tr;
    mx_b   = (v_bl > v_br) ? v_bl : v_br;
    mn_t   = (v_tl < v_tr) ? v_tl : v_tr;
    mn_b   = (v_bl < v_br) ? v_bl : v_br;
    v_max  = (mx_t > mx_b) ? mx_t : mx_b;
    v_min  = (mn_t < mn_b) ? mn_t : mn_b;
    sum    = {2'b00, v_tl} + {2'b00, v_tr} + {2'b00, v_bl} + {2'b00, v_br};
    wr_nxt = bus.IRAM_A + 6'd1;
    accept = bus.cmd_valid && !bus.busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (bus.IROM_rd && bus.IROM_A == 6'd63) state_nxt = S_IDLE;
      S_IDLE:  if (accept) state_nxt = (bus.cmd == 4'd0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_nxt = S_IDLE;
      S_WRITE: if (bus.IRAM_valid && bus.IRAM_A == 6'd63) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy       <= 1'b1;
      bus.done       <= 1'b0;
      bus.IROM_rd    <= 1'b0;
      bus.IROM_A     <= '0;
      bus.IRAM_valid <= 1'b0;
      bus.IRAM_A     <= '0;
      bus.IRAM_D     <= '0;
      px             <= 3'd4;
      py             <= 3'd4;
      cmd_q          <= 4'd0;
    end else begin
      case (state)
        S_LOAD: begin
          // first cycle only raises rd; afterwards Q belongs to the address currently held
          if (!bus.IROM_rd) bus.IROM_rd <= 1'b1;
          else if (bus.IROM_A == 6'd63) begin
            bus.IROM_rd <= 1'b0;
            bus.busy    <= 1'b0;
          end else bus.IROM_A <= bus.IROM_A + 6'd1;
        end
        S_IDLE: if (accept) begin
          cmd_q    <= bus.cmd;
          bus.busy <= 1'b1;
        end
        S_EXEC: begin
          bus.busy <= 1'b0;
          case (cmd_q)
            4'd1: if (py > 3'd1) py <= py - 3'd1;
            4'd2: if (py < 3'd7) py <= py + 3'd1;
            4'd3: if (px > 3'd1) px <= px - 3'd1;
            4'd4: if (px < 3'd7) px <= px + 3'd1;
            default: ;
          endcase
        end
        S_WRITE: begin
          if (!bus.IRAM_valid) begin
            bus.IRAM_valid <= 1'b1;
            bus.IRAM_A     <= '0;
            bus.IRAM_D     <= pix[0];
          end else if (bus.IRAM_A == 6'd63) begin
            bus.IRAM_valid <= 1'b0;
            bus.done       <= 1'b1;
          end else begin
            bus.IRAM_A <= wr_nxt;
            bus.IRAM_D <= pix[wr_nxt];
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.IROM_rd) pix[bus.IROM_A] <= bus.IROM_Q;
    else if (state == S_EXEC) begin
      case (cmd_q)
        4'd5: begin
          pix[a_tl] <= v_max; pix[a_tr] <= v_max; pix[a_bl] <= v_max; pix[a_br] <= v_max;
        end
        4'd6: begin
          pix[a_tl] <= v_min; pix[a_tr] <= v_min; pix[a_bl] <= v_min; pix[a_br] <= v_min;
        end
        4'd7: begin
          pix[a_tl] <= sum[DW+1:2]; pix[a_tr] <= sum[DW+1:2];
          pix[a_bl] <= sum[DW+1:2]; pix[a_br] <= sum[DW+1:2];
        end
        4'd8: begin
          pix[a_tl] <= v_tr; pix[a_tr] <= v_br; pix[a_br] <= v_bl; pix[a_bl] <= v_tl;
        end
        4'd9: begin
          pix[a_tl] <= v_bl; pix[a_tr] <= v_tl; pix[a_br] <= v_tr; pix[a_bl] <= v_br;
        end
        4'd10: begin
          pix[a_tl] <= v_bl; pix[a_bl] <= v_tl; pix[a_tr] <= v_br; pix[a_br] <= v_tr;
        end
        4'd11: begin
          pix[a_tl] <= v_tr; pix[a_tr] <= v_tl; pix[a_bl] <= v_br; pix[a_br] <= v_bl;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed and random command checks of lcd_ctrl against an image model
module tb_lcd_ctrl;
  logic clk = 1'b0;
  logic reset;
  lcd_ctrl_if bus();

  lcd_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  logic [7:0] rom [64];
  logic [7:0] ram [64];
  int         img [64];
  int         mx, my;
  int         n_cmp = 0;
  int         n_err = 0;

  // sync ROM: registers the addressed word on the falling edge
  always @(negedge clk) if (bus.IROM_rd) bus.IROM_Q <= rom[bus.IROM_A];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input int c);
    int tl, tr, bl, br, a, b, e, d, v;
    tl = (my - 1) * 8 + mx - 1; tr = tl + 1; bl = tl + 8; br = bl + 1;
    a = img[tl]; b = img[tr]; e = img[bl]; d = img[br];
    case (c)
      1: if (my > 1) my--;
      2: if (my < 7) my++;
      3: if (mx > 1) mx--;
      4: if (mx < 7) mx++;
      5: begin
        v = a; if (b > v) v = b; if (e > v) v = e; if (d > v) v = d;
        img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v;
      end
      6: begin
        v = a; if (b < v) v = b; if (e < v) v = e; if (d < v) v = d;
        img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v;
      end
      7: begin
        v = (a + b + e + d) / 4;
        img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v;
      end
      8:  begin img[tl] = b; img[tr] = d; img[br] = e; img[bl] = a; end
      9:  begin img[tl] = e; img[tr] = a; img[br] = b; img[bl] = d; end
      10: begin img[tl] = e; img[bl] = a; img[tr] = d; img[br] = b; end
      11: begin img[tl] = b; img[tr] = a; img[bl] = d; img[br] = e; end
      default: ;
    endcase
  endtask

  task automatic load_wait(input bit chk);
    int cyc, rd_cnt, bad;
    cyc = 0; rd_cnt = 0; bad = 0;
    while (bus.busy && cyc < 200) begin
      if (bus.IROM_rd) begin
        if (bus.IROM_A != 6'(rd_cnt)) bad++;
        rd_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    check("load_finishes", 32'(bus.busy), 32'd0);
    if (chk) begin
      check("load_rd_cycles", 32'(rd_cnt), 32'd64);
      check("load_addr_steps", 32'(bad), 32'd0);
    end
    for (int i = 0; i < 64; i++) img[i] = int'(rom[i]);
    mx = 4; my = 4;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load_wait(chk);
  endtask

  task automatic issue(input int c);
    int g;
    g = 0;
    while (bus.busy && g < 200) begin @(negedge clk); g++; end
    check("issue_ready", 32'(bus.busy), 32'd0);
    bus.cmd = 4'(c);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic do_cmd(input int c);
    issue(c);
    model_cmd(c);
    @(negedge clk);
    check("exec_one_cycle", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_write();
    int wcnt, dcnt, last, dcyc, bad, pbad;
    wcnt = 0; dcnt = 0; last = -10; dcyc = -1; bad = 0; pbad = 0;
    for (int i = 0; i < 64; i++) ram[i] = 8'hxx;
    issue(0);
    for (int c = 0; c < 150; c++) begin
      if (bus.IRAM_valid) begin
        if (bus.IRAM_A != 6'(wcnt)) bad++;
        ram[bus.IRAM_A] = bus.IRAM_D;
        wcnt++; last = c;
      end
      if (bus.done) begin dcnt++; dcyc = c; end
      if (dcnt > 0 && !bus.busy) break;
      @(negedge clk);
    end
    check("write_count", 32'(wcnt), 32'd64);
    check("write_addr_order", 32'(bad), 32'd0);
    check("done_pulses", 32'(dcnt), 32'd1);
    check("done_after_last", 32'(dcyc), 32'(last + 1));
    for (int i = 0; i < 64; i++) if (ram[i] !== 8'(img[i])) pbad++;
    check("image_matches_model", 32'(pbad), 32'd0);
  endtask

  initial begin
    int dbad, m;
    reset = 1'b0;
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_irom_rd", 32'(bus.IROM_rd), 32'd0);
    check("rst_irom_a", 32'(bus.IROM_A), 32'd0);
    check("rst_iram_valid", 32'(bus.IRAM_valid), 32'd0);
    check("rst_iram_a", 32'(bus.IRAM_A), 32'd0);
    check("rst_iram_d", 32'(bus.IRAM_D), 32'd0);
    reset = 1'b1;
    load_wait(1'b1);
    do_write();
    check("ident_px45", 32'(ram[45]), 32'd45);

    do_cmd(5);
    do_write();
    check("max_px27", 32'(ram[27]), 32'd36);
    check("max_px35", 32'(ram[35]), 32'd36);
    check("max_px26_kept", 32'(ram[26]), 32'd26);

    do_reset(1'b0);
    do_cmd(6);
    do_write();
    check("min_px36", 32'(ram[36]), 32'd27);

    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[27] = 8'd1; rom[28] = 8'd2; rom[35] = 8'd3; rom[36] = 8'd5;
    do_reset(1'b0);
    do_cmd(7);
    do_write();
    check("avg_px28", 32'(ram[28]), 32'd2);

    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    do_reset(1'b0);
    do_cmd(9);
    do_write();
    check("cw_tl", 32'(ram[27]), 32'(rom[35]));
    check("cw_tr", 32'(ram[28]), 32'(rom[27]));
    check("cw_br", 32'(ram[36]), 32'(rom[28]));
    check("cw_bl", 32'(ram[35]), 32'(rom[36]));
    do_cmd(8);
    do_write();
    check("ccw_restore_tl", 32'(ram[27]), 32'(rom[27]));

    do_reset(1'b0);
    repeat (4) do_cmd(1);
    do_cmd(5);
    do_write();
    m = rom[3];
    if (rom[4] > m) m = rom[4];
    if (rom[11] > m) m = rom[11];
    if (rom[12] > m) m = rom[12];
    check("top_max_px3", 32'(ram[3]), 32'(m));
    check("top_max_px12", 32'(ram[12]), 32'(m));
    check("top_px19_kept", 32'(ram[19]), 32'(rom[19]));
    repeat (8) do_cmd(4);
    do_cmd(5);
    do_write();
    m = rom[6];
    if (rom[7] > m) m = rom[7];
    if (rom[14] > m) m = rom[14];
    if (rom[15] > m) m = rom[15];
    check("right_max_px7", 32'(ram[7]), 32'(m));
    check("right_max_px14", 32'(ram[14]), 32'(m));

    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 40; j++) do_cmd(int'($urandom_range(15, 1)));
      do_write();
    end

    issue(0);
    dbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dbad++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (bus.done) dbad++;
    check("midwrite_rst_valid", 32'(bus.IRAM_valid), 32'd0);
    check("midwrite_rst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (bus.done) dbad++;
    check("restart_rd", 32'(bus.IROM_rd), 32'd1);
    check("restart_a0", 32'(bus.IROM_A), 32'd0);
    @(negedge clk);
    check("restart_a1", 32'(bus.IROM_A), 32'd1);
    load_wait(1'b0);
    check("midwrite_no_done", 32'(dbad), 32'd0);
    do_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
